alu_opa_stage: RTL and testbench

- Registered ALU operand-A select stage for the pipelined RV32I core, sitting on the ID/EX boundary.
- Selects one of four sources for operand A: zero (LUI), PC (AUIPC), a forwarded result, or the register-file read data rd1.
- Parametrised in data width and in the number of forwarding sources.
- Adds a valid/ready pipeline register, load-use stall detection, flush, and a saturating stall counter.

---
 rtl/alu_opa_stage.sv | 125 ++++++++++++
 tb/tb_alu_opa_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_opa_stage.sv
// ID/EX operand-A select stage. It chooses zero, PC, a forwarded result or rd1,
// registers the choice behind a valid/ready pipeline register and counts load-use stall cycles.
module alu_opa_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    aui,
    input  logic                    lui,
    input  logic [4:0]              rs1,
    input  logic [XLEN-1:0]         rd1,
    input  logic [XLEN-1:0]         pc,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         alu1,
    output logic [1:0]              out_src,
    output logic [CNT_W-1:0]        stall_cnt
);
    localparam logic [1:0] SRC_RD1  = 2'd0;
    localparam logic [1:0] SRC_PC   = 2'd1;
    localparam logic [1:0] SRC_FWD  = 2'd2;
    localparam logic [1:0] SRC_ZERO = 2'd3;

    logic             fwd_hit;
    logic [XLEN-1:0]  fwd_sel_data;
    logic             fwd_sel_pend;
    logic [XLEN-1:0]  sel_data;
    logic [1:0]       sel_src;
    logic             hazard;
    logic             capture;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  alu1_q, alu1_d;
    logic [1:0]       src_q, src_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Scan from the oldest source down so the lowest matching index wins.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_sel_data = '0;
        fwd_sel_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs1)) begin
                fwd_hit      = 1'b1;
                fwd_sel_data = fwd_data[XLEN*i +: XLEN];
                fwd_sel_pend = fwd_pending[i];
            end
        end
        if (rs1 == 5'd0) begin
            fwd_hit      = 1'b0;
            fwd_sel_pend = 1'b0;
        end
    end

    always_comb begin
        sel_data = rd1;
        sel_src  = SRC_RD1;
        if (lui) begin
            sel_data = '0;
            sel_src  = SRC_ZERO;
        end else if (aui) begin
            sel_data = pc;
            sel_src  = SRC_PC;
        end else if (fwd_hit) begin
            sel_data = fwd_sel_data;
            sel_src  = SRC_FWD;
        end
    end

    assign hazard = in_valid && !lui && !aui && fwd_hit && fwd_sel_pend;

    // Valid/ready: a transfer happens on a cycle where valid and ready are both high.
    // Upstream holds its instruction until in_ready; downstream must keep alu1 and
    // out_src stable while out_valid is high and out_ready is low.
    assign in_ready = (!out_valid_q || out_ready) && !hazard;
    assign capture  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu1_d      = alu1_q;
        src_d       = src_q;
        stall_cnt_d = stall_cnt_q;
        if (capture) begin
            alu1_d = sel_data;
            src_d  = sel_src;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hazard && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            alu1_q      <= '0;
            src_q       <= SRC_RD1;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu1_q      <= alu1_d;
            src_q       <= src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu1      = alu1_q;
    assign out_src   = src_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_alu_opa_stage.sv
// Bench for alu_opa_stage: directed cases followed by random traffic, all checked
// against a cycle-level behavioural model; a second instance with a 2-bit counter covers saturation.
module tb_alu_opa_stage;
    localparam int XLEN = 32;
    localparam int NF   = 2;
    localparam int CW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, in_valid, aui, lui, flush, out_ready;
    logic [4:0]        rs1;
    logic [XLEN-1:0]   rd1, pc;
    logic              fv[NF];
    logic [4:0]        frd[NF];
    logic [XLEN-1:0]   fdata[NF];
    logic              fpend[NF];
    logic [NF-1:0]     fwd_valid, fwd_pending;
    logic [5*NF-1:0]   fwd_rd;
    logic [XLEN*NF-1:0] fwd_data;

    logic              in_ready, out_valid, sat_in_ready, sat_out_valid;
    logic [XLEN-1:0]   alu1, sat_alu1;
    logic [1:0]        out_src, sat_out_src;
    logic [CW-1:0]     stall_cnt;
    logic [1:0]        sat_stall_cnt;

    always_comb begin
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_rd      = '0;
        fwd_data    = '0;
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]             = fv[i];
            fwd_pending[i]           = fpend[i];
            fwd_rd[5*i +: 5]         = frd[i];
            fwd_data[XLEN*i +: XLEN] = fdata[i];
        end
    end

    alu_opa_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(CW)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .aui(aui), .lui(lui), .rs1(rs1), .rd1(rd1), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu1(alu1), .out_src(out_src), .stall_cnt(stall_cnt)
    );

    alu_opa_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(sat_in_ready),
        .aui(aui), .lui(lui), .rs1(rs1), .rd1(rd1), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .flush(flush), .out_valid(sat_out_valid),
        .out_ready(out_ready), .alu1(sat_alu1), .out_src(sat_out_src), .stall_cnt(sat_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the stage should hold after the last edge.
    logic            m_valid;
    logic [XLEN-1:0] m_alu1;
    logic [1:0]      m_src;
    int              m_cnt, m_cnt2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Operand A from the ISA rules: LUI reads zero, AUIPC reads the PC, otherwise the
    // youngest in-flight producer of rs1 (x0 excluded), else the register file.
    function automatic void ref_select(output logic [XLEN-1:0] d, output logic [1:0] c,
                                       output logic haz);
        int win;
        win = -1;
        if (rs1 != 5'd0)
            for (int i = 0; i < NF; i++)
                if (win < 0 && fv[i] && frd[i] == rs1) win = i;
        haz = 1'b0;
        if (lui) begin
            d = '0; c = 2'd3;
        end else if (aui) begin
            d = pc; c = 2'd1;
        end else if (win >= 0) begin
            d = fdata[win]; c = 2'd2; haz = fpend[win] && in_valid;
        end else begin
            d = rd1; c = 2'd0;
        end
    endfunction

    // One clock: check in_ready, advance the model, let the edge happen, check outputs.
    task automatic tick();
        logic [XLEN-1:0] sd;
        logic [1:0]      sc;
        logic            hz, rdy, cap, was_rst;
        #1;
        ref_select(sd, sc, hz);
        rdy = (!m_valid || out_ready) && !hz;
        check("in_ready", 32'(in_ready), 32'(rdy));
        was_rst = !rstn;
        if (was_rst) begin
            m_valid = 1'b0; m_alu1 = '0; m_src = 2'd0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            cap = in_valid && rdy;
            if (cap) begin
                m_alu1 = sd;
                m_src  = sc;
            end
            if (flush)          m_valid = 1'b0;
            else if (cap)       m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
            if (hz && !flush) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("sat_stall_cnt", 32'(sat_stall_cnt), 32'(m_cnt2));
        if (m_valid || was_rst) begin
            check("alu1", alu1, m_alu1);
            check("out_src", 32'(out_src), 32'(m_src));
        end
    endtask

    task automatic set_idle();
        in_valid = 1'b0; aui = 1'b0; lui = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1 = 5'd0; rd1 = '0; pc = '0;
        for (int i = 0; i < NF; i++) begin
            fv[i] = 1'b0; frd[i] = 5'd0; fdata[i] = '0; fpend[i] = 1'b0;
        end
    endtask

    initial begin
        logic [XLEN-1:0] v;
        int base;
        m_valid = 1'b0; m_alu1 = '0; m_src = 2'd0; m_cnt = 0; m_cnt2 = 0;
        set_idle();

        // Reset held two cycles with a valid instruction waiting.
        rstn = 1'b0; in_valid = 1'b1; rs1 = 5'd5; rd1 = 32'h0000_1234;
        tick();
        tick();
        check("rst_alu1", alu1, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        rstn = 1'b1;
        tick();
        check("first_capture_valid", 32'(out_valid), 32'h1);
        check("first_capture_alu1", alu1, 32'h0000_1234);

        // Source select.
        lui = 1'b1; aui = 1'b1; pc = 32'h0000_1000;
        tick();
        check("lui_alu1", alu1, 32'h0);
        check("lui_src", 32'(out_src), 32'd3);
        lui = 1'b0;
        tick();
        check("aui_alu1", alu1, 32'h0000_1000);
        check("aui_src", 32'(out_src), 32'd1);
        aui = 1'b0; rs1 = 5'd5; rd1 = 32'hDEAD_BEEF;
        tick();
        check("rd1_alu1", alu1, 32'hDEAD_BEEF);
        check("rd1_src", 32'(out_src), 32'd0);

        // Forward priority and x0.
        rs1 = 5'd7; fv[0] = 1'b1; fv[1] = 1'b1; frd[0] = 5'd7; frd[1] = 5'd7;
        fdata[0] = 32'h11; fdata[1] = 32'h22;
        tick();
        check("fwd_prio_alu1", alu1, 32'h11);
        check("fwd_prio_src", 32'(out_src), 32'd2);
        rs1 = 5'd0; frd[0] = 5'd0; frd[1] = 5'd0; rd1 = 32'h0000_CAFE;
        tick();
        check("x0_alu1", alu1, 32'h0000_CAFE);

        // Load-use stall for three cycles, then the load data arrives.
        set_idle();
        in_valid = 1'b1; rs1 = 5'd3; fv[0] = 1'b1; frd[0] = 5'd3; fpend[0] = 1'b1;
        base = m_cnt;
        repeat (3) begin
            #1 check("stall_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        check("stall_cnt_plus3", 32'(stall_cnt), 32'(base + 3));
        fpend[0] = 1'b0; fdata[0] = 32'h55;
        tick();
        check("load_use_alu1", alu1, 32'h55);

        // Backpressure, then full throughput.
        set_idle();
        in_valid = 1'b1; rs1 = 5'd9; out_ready = 1'b0;
        repeat (4) begin
            rd1 = $urandom;
            tick();
        end
        out_ready = 1'b1;
        repeat (4) begin
            v = $urandom;
            rd1 = v;
            tick();
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_alu1", alu1, v);
        end

        // Flush during a capture.
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(out_valid), 32'h0);
        flush = 1'b0;

        // Six hazard cycles saturate the 2-bit counter.
        set_idle();
        in_valid = 1'b1; rs1 = 5'd3; fv[0] = 1'b1; frd[0] = 5'd3; fpend[0] = 1'b1;
        repeat (6) tick();
        check("sat_at_max", 32'(sat_stall_cnt), 32'd3);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            lui       = ($urandom_range(0, 9) == 0);
            aui       = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rs1       = 5'($urandom_range(0, 7));
            rd1       = $urandom;
            pc        = $urandom;
            for (int i = 0; i < NF; i++) begin
                fv[i]    = ($urandom_range(0, 1) == 1);
                frd[i]   = 5'($urandom_range(0, 7));
                fdata[i] = $urandom;
                fpend[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
